kd_tree_node_sender: RTL and testbench

//  Transmit side of the internal-node write stream for the KD-tree. The tree

---
 rtl/kd_tree_node_sender.sv | 130 +++++++++++++
 tb/tb_kd_tree_node_sender.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/kd_tree_node_sender.sv
// kd_tree_node_sender
//   Streams NUM_NODES internal-node records from a node memory (1-cycle read
//   latency) to the KD-tree's internal-node write port. A 2-entry prefetch
//   FIFO decouples memory reads from the tree's sender_ready backpressure.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   start          1-cycle request to begin a tree load (ignored unless idle)
//   busy           high while loading/draining
//   done           1-cycle pulse after the last word is accepted
//   mem_ren        node-memory read enable
//   mem_addr       node-memory read address
//   mem_rdata      node-memory read data, valid the cycle after mem_ren
//   sender_enable  word valid toward the tree (FIFO not empty)
//   sender_data    node record toward the tree (FIFO head, registered)
//   sender_ready   tree accepts the presented word this cycle
module kd_tree_node_sender #(
  parameter int INTERNAL_WIDTH = 22,
  parameter int NUM_NODES      = 127,
  parameter int ADDRESS_WIDTH  = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_ren,
  output logic [ADDRESS_WIDTH-1:0]  mem_addr,
  input  logic [INTERNAL_WIDTH-1:0] mem_rdata,
  output logic                      sender_enable,
  output logic [INTERNAL_WIDTH-1:0] sender_data,
  input  logic                      sender_ready
);

  localparam int CNT_W = $clog2(NUM_NODES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_NODES - 1);
  localparam logic [CNT_W-1:0] NUM_CNT  = CNT_W'(NUM_NODES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          issue_cnt;
  logic [CNT_W-1:0]          sent_cnt;
  logic [1:0]                fifo_cnt;
  logic [INTERNAL_WIDTH-1:0] fifo_d0;
  logic [INTERNAL_WIDTH-1:0] fifo_d1;
  logic                      vld_p1;
  logic                      pop;
  logic                      push;
  logic [2:0]                occ_after;

  assign sender_enable = (fifo_cnt != 2'd0);
  assign sender_data   = fifo_d0;
  assign mem_addr      = ADDRESS_WIDTH'(issue_cnt);

  assign pop  = sender_enable & sender_ready;
  assign push = vld_p1;

  // Occupancy the FIFO will have once the in-flight read lands and this
  // cycle's pop (if any) retires; a new read is only issued if it still fits.
  // pop implies fifo_cnt >= 1, so this never underflows.
  assign occ_after = {1'b0, fifo_cnt} + {2'b00, vld_p1} - {2'b00, pop};

  always_comb begin
    state_nxt = state;
    mem_ren   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        busy = 1'b1;
        if ((issue_cnt < NUM_CNT) && (occ_after < 3'd2)) mem_ren = 1'b1;
        if (mem_ren && (issue_cnt == LAST_IDX)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (pop && (sent_cnt == LAST_IDX)) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p0 -> p1: read issue, in-flight flag, counters and FIFO head
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      issue_cnt <= '0;
      sent_cnt  <= '0;
      vld_p1    <= 1'b0;
      fifo_cnt  <= 2'd0;
      fifo_d0   <= '0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= mem_ren;
      if ((state == S_IDLE) && start) begin
        issue_cnt <= '0;
        sent_cnt  <= '0;
      end else begin
        if (mem_ren) issue_cnt <= issue_cnt + 1'b1;
        if (pop)     sent_cnt  <= sent_cnt + 1'b1;
      end
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
      case ({push, pop})
        2'b10: if (fifo_cnt == 2'd0) fifo_d0 <= mem_rdata;
        2'b01: fifo_d0 <= fifo_d1;
        2'b11: fifo_d0 <= (fifo_cnt == 2'd1) ? mem_rdata : fifo_d1;
        default: ;
      endcase
    end
  end

  // Second FIFO slot: data only, validity tracked by fifo_cnt
  always_ff @(posedge clk) begin
    if (push && ((!pop && (fifo_cnt != 2'd0)) || (pop && (fifo_cnt == 2'd2))))
      fifo_d1 <= mem_rdata;
  end

endmodule

// File: tb/tb_kd_tree_node_sender.sv
module tb_kd_tree_node_sender;

  localparam int W  = 22;
  localparam int N  = 127;
  localparam int AW = 7;

  localparam int M_FULL    = 0;
  localparam int M_TOGGLE  = 1;
  localparam int M_HOLD20  = 2;
  localparam int M_RESTART = 3;
  localparam int M_RANDOM  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, mem_ren;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_rdata = '0;
  logic          sender_enable;
  logic [W-1:0]  sender_data;
  logic          sender_ready = 1'b0;

  logic [W-1:0]  mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_fail   = 0;

  kd_tree_node_sender #(
    .INTERNAL_WIDTH(W),
    .NUM_NODES(N),
    .ADDRESS_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .busy(busy),
    .done(done),
    .mem_ren(mem_ren),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .sender_enable(sender_enable),
    .sender_data(sender_data),
    .sender_ready(sender_ready)
  );

  always #5 clk = ~clk;

  // Node memory with 1-cycle read latency
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill_mem(input bit incr);
    for (int k = 0; k < (1 << AW); k++)
      mem[k] = incr ? W'(k + 'h100) : W'($urandom);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_ren"},  mem_ren, 0);
    check_eq({tag, "_addr"}, mem_addr, 0);
    check_eq({tag, "_vld"},  sender_enable, 0);
    check_eq({tag, "_data"}, sender_data, 0);
  endtask

  // One tree load. Entered #1 after a posedge; that posedge's successor is
  // edge 0 (start seen). Cycle c is the interval following edge c-1.
  // Reference: the tree must receive mem[0..N-1] exactly once, in order.
  task automatic run_load(input int mode, input int rst_cyc, input int max_c);
    int       idx;
    int       reads;
    int       dones;
    int       done_c;
    logic     stall_prev;
    logic [W-1:0] data_prev;
    idx = 0; reads = 0; dones = 0; done_c = -1; stall_prev = 1'b0; data_prev = '0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= max_c; c++) begin
      case (mode)
        M_TOGGLE: sender_ready = c[0];
        M_HOLD20: sender_ready = (c > 20);
        M_RANDOM: sender_ready = ($urandom_range(0, 3) != 0);
        default:  sender_ready = 1'b1;
      endcase
      start = (mode == M_RESTART) && (c == 5 || c == N + 3);
      rst   = (rst_cyc > 0) && (c == rst_cyc);
      @(negedge clk);
      if (rst_cyc > 0 && c == rst_cyc + 1) begin
        check_outputs_zero("abort");
        check_eq("abort_no_done", dones, 0);
        @(posedge clk);
        #1;
        sender_ready = 1'b0;
        return;
      end
      check_eq("fifo_occ_le2", {31'd0, dut.fifo_cnt <= 2'd2}, 1);
      check_eq("busy", busy, (dones == 0) && !done);
      if (mem_ren) begin
        check_eq("rd_addr", mem_addr, reads);
        reads++;
      end
      if (stall_prev) begin
        check_eq("stall_vld", sender_enable, 1);
        check_eq("stall_data", sender_data, data_prev);
      end
      if (dones > 0 && !done) check_eq("vld_after_done", sender_enable, 0);
      if (sender_enable && sender_ready) begin
        if (idx < N) begin
          check_eq("word", sender_data, mem[idx]);
          if (mode == M_FULL || mode == M_RESTART) check_eq("word_cycle", c, idx + 3);
          if (mode == M_HOLD20) check_eq("word_cycle_resume", c, idx + 21);
        end else begin
          check_eq("extra_word", idx, N - 1);
        end
        idx++;
      end
      if (mode == M_HOLD20 && c == 20) begin
        check_eq("hold_reads", reads, 2);
        check_eq("hold_vld", sender_enable, 1);
        check_eq("hold_data", sender_data, mem[0]);
      end
      if (done) begin
        dones++;
        done_c = c;
        check_eq("done_after_last", idx, N);
        if (mode == M_FULL || mode == M_RESTART) check_eq("done_cycle", c, N + 3);
        if (mode == M_HOLD20) check_eq("done_cycle_hold", c, N + 21);
      end
      stall_prev = sender_enable & !sender_ready;
      data_prev  = sender_data;
      if (done_c > 0 && c >= done_c + 4) break;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    sender_ready = 1'b0;
    check_eq("words_total", idx, N);
    check_eq("reads_total", reads, N);
    check_eq("done_pulses", dones, 1);
    idle(1);
  endtask

  initial begin
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // T1: full rate, incrementing contents
    fill_mem(1'b1);
    run_load(M_FULL, 0, N + 20);
    idle(3);

    // T2: alternating ready
    fill_mem(1'b0);
    run_load(M_TOGGLE, 0, 2 * N + 30);
    idle(3);

    // T3: ready held low for 20 cycles
    fill_mem(1'b0);
    run_load(M_HOLD20, 0, N + 40);
    idle(3);

    // T4: extra start pulses during load and in the done cycle
    fill_mem(1'b1);
    run_load(M_RESTART, 0, N + 20);
    idle(3);

    // T5: reset mid-load, then a fresh load from address 0
    fill_mem(1'b0);
    run_load(M_FULL, 40, N + 20);
    rst = 1'b0;
    idle(8);
    run_load(M_FULL, 0, N + 20);
    idle(3);

    // Random backpressure runs
    for (int r = 0; r < 3; r++) begin
      fill_mem(1'b0);
      run_load(M_RANDOM, 0, 4 * N + 40);
      idle($urandom_range(1, 5));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
